// File: rtl/rx_sync_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : rx_sync_ctrl_if
// Brief    : Word-status strobe and sync-status bundle for rx_sync_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rx_sync_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             wordValid;
  logic             comma;
  logic             codeErr;
  logic             rdErr;
  logic             errClr;
  logic             synced;
  logic             realign;
  logic [1:0]       syncState;
  logic [3:0]       errLevel;
  logic [CNT_W-1:0] errCount;

  modport master (
    output wordValid, comma, codeErr, rdErr, errClr,
    input  synced, realign, syncState, errLevel, errCount
  );

  modport slave (
    input  wordValid, comma, codeErr, rdErr, errClr,
    output synced, realign, syncState, errLevel, errCount
  );
endinterface

`default_nettype wire

// File: rtl/rx_sync_ctrl.sv
//------------------------------------------------------------------------------
// Module   : rx_sync_ctrl
// Brief    : SERDES RX word-sync controller: comma lock, leaky error budget,
//            loss-of-sync realign pulse. RX_SYNC_ERRCNT_EN builds errCount.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rx_sync_ctrl #(
  parameter int LOCK_COMMAS = 3,
  parameter int MAX_ERR     = 4,
  parameter int GOOD_RUN    = 4,
  parameter int CNT_W       = 16
) (
  input  wire logic     clk,
  input  wire logic     reset,
  rx_sync_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_LOSS = 2'd0,
    ST_ACQ  = 2'd1,
    ST_SYNC = 2'd2
  } state_t;

  localparam logic [4:0] c_LOCK = 5'(LOCK_COMMAS);
  localparam logic [4:0] c_MAX  = 5'(MAX_ERR);
  localparam logic [8:0] c_GOOD = 9'(GOOD_RUN);

  state_t     r_state;
  logic [3:0] r_comma_cnt;
  logic [7:0] r_good_cnt;
  logic [3:0] r_err_level;
  logic       r_realign;

  state_t     w_state_nxt;
  logic [3:0] w_comma_nxt;
  logic [7:0] w_good_nxt;
  logic [3:0] w_level_nxt;
  logic       w_realign_nxt;

  logic       w_bad;
  logic       w_good_comma;
  logic [4:0] w_comma_inc;
  logic [4:0] w_level_inc;
  logic [8:0] w_good_inc;

  assign w_bad        = bus.codeErr | bus.rdErr;
  assign w_good_comma = bus.comma & ~w_bad;
  assign w_comma_inc  = {1'b0, r_comma_cnt} + 5'd1;
  assign w_level_inc  = {1'b0, r_err_level} + 5'd1;
  assign w_good_inc   = {1'b0, r_good_cnt} + 9'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_LOSS;
      r_comma_cnt <= 4'd0;
      r_good_cnt  <= 8'd0;
      r_err_level <= 4'd0;
      r_realign   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_comma_cnt <= w_comma_nxt;
      r_good_cnt  <= w_good_nxt;
      r_err_level <= w_level_nxt;
      r_realign   <= w_realign_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_comma_nxt   = r_comma_cnt;
    w_good_nxt    = r_good_cnt;
    w_level_nxt   = r_err_level;
    w_realign_nxt = 1'b0;

    case (r_state)
      ST_LOSS: begin
        if (bus.wordValid && w_good_comma) begin
          w_state_nxt = ST_ACQ;
          w_comma_nxt = 4'd1;
        end
      end

      ST_ACQ: begin
        if (bus.wordValid) begin
          if (w_bad) begin
            w_state_nxt   = ST_LOSS;
            w_comma_nxt   = 4'd0;
            w_realign_nxt = 1'b1;
          end else if (bus.comma) begin
            // >= lets LOCK_COMMAS=1 lock on the comma after the entry comma
            if (w_comma_inc >= c_LOCK) begin
              w_state_nxt = ST_SYNC;
              w_comma_nxt = c_LOCK[3:0];
              w_level_nxt = 4'd0;
              w_good_nxt  = 8'd0;
            end else begin
              w_comma_nxt = w_comma_inc[3:0];
            end
          end
        end
      end

      ST_SYNC: begin
        if (bus.wordValid) begin
          if (w_bad) begin
            w_good_nxt = 8'd0;
            if (w_level_inc >= c_MAX) begin
              w_state_nxt   = ST_LOSS;
              w_level_nxt   = 4'd0;
              w_comma_nxt   = 4'd0;
              w_realign_nxt = 1'b1;
            end else begin
              w_level_nxt = w_level_inc[3:0];
            end
          end else if (w_good_inc >= c_GOOD) begin
            w_good_nxt = 8'd0;
            if (r_err_level != 4'd0) begin
              w_level_nxt = r_err_level - 4'd1;
            end
          end else begin
            w_good_nxt = w_good_inc[7:0];
          end
        end
      end

      default: begin
        w_state_nxt = ST_LOSS;
        w_comma_nxt = 4'd0;
        w_good_nxt  = 8'd0;
        w_level_nxt = 4'd0;
      end
    endcase
  end

  assign bus.synced    = (r_state == ST_SYNC);
  assign bus.syncState = r_state;
  assign bus.errLevel  = r_err_level;
  assign bus.realign   = r_realign;

`ifdef RX_SYNC_ERRCNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  // Clear wins over a coincident bad word; count saturates at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (bus.errClr) begin
      r_err_cnt <= '0;
    end else if (bus.wordValid && w_bad && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.errCount = r_err_cnt;
`else
  logic w_unused_errclr;
  assign w_unused_errclr = bus.errClr;
  assign bus.errCount    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_sync_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_rx_sync_ctrl
// Brief    : Directed vector bench for rx_sync_ctrl (LOCK=3, MAX_ERR=4,
//            GOOD_RUN=4, CNT_W=2). Expected errCount honours RX_SYNC_ERRCNT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rx_sync_ctrl;

  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rx_sync_ctrl_if #(.CNT_W(CNT_W)) bus ();

  rx_sync_ctrl #(
    .LOCK_COMMAS (3),
    .MAX_ERR     (4),
    .GOOD_RUN    (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       wv, c, ce, rd, clr;
    logic [1:0] st;
    logic       ra;
    logic [3:0] lvl;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [1:0] exp_cnt(input logic [1:0] c);
`ifdef RX_SYNC_ERRCNT_EN
    return c;
`else
    return 2'd0 & c;
`endif
  endfunction

  task automatic drive(input logic wv, input logic c, input logic ce, input logic rd, input logic clr);
    bus.wordValid = wv;
    bus.comma     = c;
    bus.codeErr   = ce;
    bus.rdErr     = rd;
    bus.errClr    = clr;
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic ra,
                           input logic [3:0] lvl, input logic [1:0] cnt);
    chk({tag, ".state"},   32'(bus.syncState), 32'(st));
    chk({tag, ".synced"},  32'(bus.synced),    32'(st == 2'd2));
    chk({tag, ".realign"}, 32'(bus.realign),   32'(ra));
    chk({tag, ".level"},   32'(bus.errLevel),  32'(lvl));
    chk({tag, ".count"},   32'(bus.errCount),  32'(exp_cnt(cnt)));
  endtask

  task automatic add(input logic wv, input logic c, input logic ce, input logic rd, input logic clr,
                     input logic [1:0] st, input logic ra, input logic [3:0] lvl, input logic [1:0] cnt);
    vecs.push_back('{wv, c, ce, rd, clr, st, ra, lvl, cnt});
  endtask

  initial begin
    //   wv c  ce rd clr  st ra lvl cnt
    add(1, 1, 0, 0, 0,   1, 0, 0, 0);  // lock acquisition
    add(1, 1, 0, 0, 0,   1, 0, 0, 0);
    add(1, 1, 0, 0, 0,   2, 0, 0, 0);
    add(1, 0, 1, 0, 0,   2, 0, 1, 1);  // leaky budget
    add(1, 0, 0, 0, 0,   2, 0, 1, 1);
    add(1, 0, 0, 0, 0,   2, 0, 1, 1);
    add(1, 1, 0, 0, 0,   2, 0, 1, 1);
    add(1, 0, 0, 0, 0,   2, 0, 0, 1);
    add(1, 0, 0, 1, 0,   2, 0, 1, 2);
    add(1, 1, 1, 0, 0,   2, 0, 2, 3);
    add(0, 1, 1, 1, 0,   2, 0, 2, 3);  // gated strobes
    add(0, 1, 0, 0, 0,   2, 0, 2, 3);
    add(1, 0, 1, 1, 0,   2, 0, 3, 3);
    add(1, 0, 1, 0, 0,   0, 1, 0, 3);  // loss of sync
    add(0, 0, 0, 0, 0,   0, 0, 0, 3);
    add(1, 1, 1, 0, 0,   0, 0, 0, 3);  // bad beats comma in LOSS
    add(1, 0, 1, 0, 1,   0, 0, 0, 0);  // clear with bad word
    add(1, 0, 0, 0, 0,   0, 0, 0, 0);
    add(1, 1, 0, 0, 0,   1, 0, 0, 0);  // acquisition abort
    add(1, 1, 0, 0, 0,   1, 0, 0, 0);
    add(1, 0, 0, 1, 0,   0, 1, 0, 1);
    add(1, 1, 0, 0, 0,   1, 0, 0, 1);
    add(1, 0, 0, 0, 0,   1, 0, 0, 1);
    add(1, 1, 0, 0, 0,   1, 0, 0, 1);
    add(1, 1, 0, 0, 0,   2, 0, 0, 1);
    add(1, 0, 0, 0, 0,   2, 0, 0, 1);  // no underflow
    add(1, 0, 0, 0, 0,   2, 0, 0, 1);
    add(1, 0, 0, 0, 0,   2, 0, 0, 1);
    add(1, 0, 0, 0, 0,   2, 0, 0, 1);
    add(1, 0, 1, 0, 0,   2, 0, 1, 2);  // four bad in a row
    add(1, 0, 0, 1, 0,   2, 0, 2, 3);
    add(1, 0, 1, 0, 0,   2, 0, 3, 3);
    add(1, 0, 1, 1, 0,   0, 1, 0, 3);
    add(1, 0, 0, 0, 1,   0, 0, 0, 0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("reset", 2'd0, 1'b0, 4'd0, 2'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].wv, vecs[i].c, vecs[i].ce, vecs[i].rd, vecs[i].clr);
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].st, vecs[i].ra, vecs[i].lvl, vecs[i].cnt);
    end

    // Asynchronous reset must kill a pending realign pulse
    drive(1, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    check_all("ar.acq", 2'd1, 1'b0, 4'd0, 2'd0);
    drive(1, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    check_all("ar.loss", 2'd0, 1'b1, 4'd0, 2'd1);
    drive(0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_all("ar.reset", 2'd0, 1'b0, 4'd0, 2'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 0, 0);
      @(posedge clk);
      #1;
      check_all($sformatf("relock%0d", k), (k == 2) ? 2'd2 : 2'd1, 1'b0, 4'd0, 2'd0);
    end
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_all("idle", 2'd2, 1'b0, 4'd0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
